// File: rtl/mips32_mem_arbiter.sv
// Shares one synchronous 32-bit memory between fetch, load/store and debug loader.
// Combinational grant, registered memory strobe; read data returns two cycles after grant.
module mips32_mem_arbiter #(
   parameter int ADDR_W     = 10,
   parameter int STARVE_MAX = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_gnt,
   output logic              i_rvalid,
   output logic [31:0]       i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [31:0]       d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [31:0]       d_rdata,
   input  logic              g_req,
   input  logic              g_we,
   input  logic [ADDR_W-1:0] g_addr,
   input  logic [31:0]       g_wdata,
   output logic              g_gnt,
   output logic              g_rvalid,
   output logic [31:0]       g_rdata,
   output logic              if_stall,
   input  logic              dbg_lock,
   output logic              dbg_locked,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   localparam int SW = $clog2(STARVE_MAX + 1);

   typedef enum logic [1:0] {RUN, DRAIN, LOCKED} state_t;

   state_t            state_q, state_d;
   logic [SW-1:0]     starve_cnt_q, starve_cnt_d;
   logic              mem_en_q, mem_en_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   // Read-owner tags, bit order {g, d, i}; stage 1 aligns with mem_*, stage 2 with mem_rdata.
   logic [2:0]        tag1_q, tag1_d;
   logic [2:0]        tag2_q, tag2_d;
   logic              id_en;
   logic              i_wins;

   always_comb begin
      state_d      = state_q;
      starve_cnt_d = starve_cnt_q;
      mem_en_d     = 1'b0;
      mem_we_d     = 1'b0;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;

      id_en  = rst_n && (state_q == RUN) && !dbg_lock && !g_req;
      i_wins = (starve_cnt_q == SW'(STARVE_MAX));
      g_gnt  = rst_n & g_req;
      d_gnt  = id_en & d_req & ~(i_req & i_wins);
      i_gnt  = id_en & i_req & ~d_gnt;

      if (!i_req || i_gnt) begin
         starve_cnt_d = '0;
      end else if (d_gnt && !i_wins) begin
         starve_cnt_d = starve_cnt_q + 1'b1;
      end

      if (g_gnt) begin
         mem_en_d    = 1'b1;
         mem_we_d    = g_we;
         mem_addr_d  = g_addr;
         mem_wdata_d = g_wdata;
      end else if (d_gnt) begin
         mem_en_d    = 1'b1;
         mem_we_d    = d_we;
         mem_addr_d  = d_addr;
         mem_wdata_d = d_wdata;
      end else if (i_gnt) begin
         mem_en_d    = 1'b1;
         mem_addr_d  = i_addr;
      end

      tag1_d = {g_gnt & ~g_we, d_gnt & ~d_we, i_gnt};
      tag2_d = tag1_q;

      unique case (state_q)
         RUN: begin
            if (dbg_lock) state_d = DRAIN;
         end
         DRAIN: begin
            if (!dbg_lock) begin
               state_d = RUN;
            end else if ((tag1_q[1:0] == 2'b00) && (tag2_q[1:0] == 2'b00)) begin
               state_d = LOCKED;
            end
         end
         LOCKED: begin
            if (!dbg_lock) state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= RUN;
         starve_cnt_q <= '0;
         mem_en_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         tag1_q       <= '0;
         tag2_q       <= '0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
         mem_en_q     <= mem_en_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         tag1_q       <= tag1_d;
         tag2_q       <= tag2_d;
      end
   end

   assign mem_en     = mem_en_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign i_rvalid   = tag2_q[0];
   assign d_rvalid   = tag2_q[1];
   assign g_rvalid   = tag2_q[2];
   assign i_rdata    = mem_rdata;
   assign d_rdata    = mem_rdata;
   assign g_rdata    = mem_rdata;
   assign if_stall   = i_req & ~i_gnt;
   assign dbg_locked = (state_q == LOCKED);

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Directed bench for mips32_mem_arbiter: grants checked per cycle, read returns
// checked by a scoreboard monitor against expected data and arrival cycle.
module tb_mips32_mem_arbiter;

   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          i_req, d_req, g_req, d_we, g_we, dbg_lock;
   logic [AW-1:0] i_addr, d_addr, g_addr;
   logic [31:0]   d_wdata, g_wdata;
   logic          i_gnt, d_gnt, g_gnt, i_rvalid, d_rvalid, g_rvalid;
   logic [31:0]   i_rdata, d_rdata, g_rdata;
   logic          if_stall, dbg_locked, mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata, mem_rdata;

   mips32_mem_arbiter #(.ADDR_W(AW), .STARVE_MAX(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .g_req(g_req), .g_we(g_we), .g_addr(g_addr), .g_wdata(g_wdata),
      .g_gnt(g_gnt), .g_rvalid(g_rvalid), .g_rdata(g_rdata),
      .if_stall(if_stall), .dbg_lock(dbg_lock), .dbg_locked(dbg_locked),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Synchronous memory model with a few preloaded words
   logic [31:0] mem [1024];
   logic        loaded = 1'b0;
   always @(posedge clk) begin
      if (!loaded) begin
         mem[10'h010] <= 32'h2801000A;
         mem[10'h020] <= 32'h12345678;
         loaded       <= 1'b1;
      end else if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata     <= mem[mem_addr];
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int fails  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   typedef struct {
      logic [31:0] data;
      int          due;
   } exp_t;

   exp_t exp_q [3][$];

   // port: 0=I, 1=D, 2=G; call during the cycle the grant is expected
   task automatic exp_rd(input int port, input logic [31:0] data);
      exp_t e;
      e.data = data;
      e.due  = cyc + 2;
      exp_q[port].push_back(e);
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      logic [2:0]  rv;
      logic [31:0] rd [3];
      rv    = {g_rvalid, d_rvalid, i_rvalid};
      rd[0] = i_rdata;
      rd[1] = d_rdata;
      rd[2] = g_rdata;
      for (int p = 0; p < 3; p++) begin
         if (exp_q[p].size() > 0 && exp_q[p][0].due <= cyc) begin
            chk($sformatf("rvalid_p%0d", p), {31'b0, rv[p]}, 32'd1);
            if (rv[p]) chk($sformatf("rdata_p%0d", p), rd[p], exp_q[p][0].data);
            void'(exp_q[p].pop_front());
         end else if (rv[p]) begin
            chk($sformatf("unexpected_rvalid_p%0d", p), {31'b0, rv[p]}, 32'd0);
         end
      end
   end

   task automatic neg();
      @(negedge clk);
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_gnt(input string name, input logic [2:0] exp_igd);
      chk(name, {29'b0, i_gnt, d_gnt, g_gnt}, {29'b0, exp_igd});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] pat;
      rst_n = 1'b0; i_req = 0; d_req = 0; g_req = 0; d_we = 0; g_we = 0; dbg_lock = 0;
      i_addr = '0; d_addr = '0; g_addr = '0; d_wdata = '0; g_wdata = '0;
      adv(); adv();
      rst_n = 1'b1;

      // 1: reset in the middle of a read
      i_req = 1; i_addr = 10'd5;
      neg(); chk_gnt("rst_pre_gnt", 3'b100);
      adv();
      rst_n = 1'b0;
      neg();
      chk_gnt("rst_gnt", 3'b000);
      chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
      chk("rst_mem_addr", {22'b0, mem_addr}, 32'd0);
      chk("rst_rvalid", {29'b0, i_rvalid, d_rvalid, g_rvalid}, 32'd0);
      chk("rst_locked", {31'b0, dbg_locked}, 32'd0);
      adv();
      rst_n = 1'b1; i_req = 0;
      adv(); adv(); adv();

      // 2: lone fetch
      i_req = 1; i_addr = 10'h010;
      neg(); chk_gnt("fetch_gnt", 3'b100); exp_rd(0, 32'h2801000A);
      adv();
      i_req = 0;
      neg();
      chk("fetch_mem_en", {31'b0, mem_en}, 32'd1);
      chk("fetch_mem_we", {31'b0, mem_we}, 32'd0);
      chk("fetch_mem_addr", {22'b0, mem_addr}, 32'h010);
      adv(); adv(); adv();

      // 3: contention, fetch forced through every fourth cycle
      pat = 8'b1000_1000;
      i_req = 1; i_addr = 10'h010; d_req = 1; d_we = 0; d_addr = 10'h020;
      for (int k = 0; k < 8; k++) begin
         neg();
         if (pat[k]) begin
            chk_gnt($sformatf("cont_gnt%0d", k), 3'b100); exp_rd(0, 32'h2801000A);
            chk($sformatf("cont_stall%0d", k), {31'b0, if_stall}, 32'd0);
         end else begin
            chk_gnt($sformatf("cont_gnt%0d", k), 3'b010); exp_rd(1, 32'h12345678);
            chk($sformatf("cont_stall%0d", k), {31'b0, if_stall}, 32'd1);
         end
         adv();
      end
      i_req = 0; d_req = 0;
      adv(); adv(); adv();

      // 4: DMEM write then read of the top word
      d_req = 1; d_we = 1; d_addr = 10'h3FF; d_wdata = 32'hDEADBEEF;
      neg(); chk_gnt("dwr_gnt", 3'b010);
      adv();
      d_we = 0;
      neg(); chk_gnt("drd_gnt", 3'b010); exp_rd(1, 32'hDEADBEEF);
      adv();
      d_req = 0;
      adv(); adv(); adv();

      // 5: lock with a DMEM read in flight
      d_req = 1; d_we = 0; d_addr = 10'h020;
      neg(); chk_gnt("lk_drd_gnt", 3'b010); exp_rd(1, 32'h12345678);
      adv();
      dbg_lock = 1; i_req = 1; i_addr = 10'h010;
      neg(); chk_gnt("lk_req_gnt", 3'b000);
      adv();
      neg(); chk_gnt("lk_drain1_gnt", 3'b000);
      chk("lk_drain1_locked", {31'b0, dbg_locked}, 32'd0);
      adv();
      neg(); chk_gnt("lk_drain2_gnt", 3'b000);
      adv();
      neg(); chk("lk_locked", {31'b0, dbg_locked}, 32'd1);
      for (int k = 0; k < 4; k++) begin
         g_req = 1; g_we = 1; g_addr = AW'(k); g_wdata = 32'hA0 + k;
         neg(); chk_gnt($sformatf("lk_gwr%0d", k), 3'b001);
         chk($sformatf("lk_held%0d", k), {31'b0, dbg_locked}, 32'd1);
         adv();
      end
      g_we = 0; g_addr = 10'd2;
      neg(); chk_gnt("lk_grd_gnt", 3'b001); exp_rd(2, 32'hA2);
      adv();
      g_req = 0; dbg_lock = 0; d_req = 0;
      neg(); chk_gnt("lk_release_gnt", 3'b000);
      adv();
      neg(); chk_gnt("lk_run_gnt", 3'b100); exp_rd(0, 32'h2801000A);
      chk("lk_run_unlocked", {31'b0, dbg_locked}, 32'd0);
      adv();
      i_req = 0;
      adv(); adv(); adv();

      // 6: three-way collision
      g_req = 1; g_we = 0; g_addr = 10'd1;
      d_req = 1; d_we = 0; d_addr = 10'h020;
      i_req = 1; i_addr = 10'h010;
      neg(); chk_gnt("col_g", 3'b001); exp_rd(2, 32'hA1);
      adv();
      g_req = 0;
      neg(); chk_gnt("col_d", 3'b010); exp_rd(1, 32'h12345678);
      adv();
      d_req = 0;
      neg(); chk_gnt("col_i", 3'b100); exp_rd(0, 32'h2801000A);
      adv();
      i_req = 0;
      adv(); adv(); adv(); adv();

      for (int p = 0; p < 3; p++)
         chk($sformatf("drained_p%0d", p), exp_q[p].size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
